// File: rtl/sseg_scan_driver_if.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver_if
//   Bundles the value-load path and the display outputs of the multiplexed
//   7-segment scan driver.
//
//   Signals:
//     value_in     signed two's-complement value to display
//     load         1-cycle strobe capturing value_in
//     pending      a loaded value is waiting for the next frame boundary
//     frame_start  1-cycle pulse in the first cycle of each frame
//     an           anode enables, active low
//     segs         segment code {g,f,e,d,c,b,a}, active low
//
//   Modports:
//     master  upstream producer of values / consumer of the display stream
//     slave   the scan driver itself
// ---------------------------------------------------------------------------
interface sseg_scan_driver_if #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 4*(NUM_DIGITS-1)
);
    logic signed [VALUE_W-1:0]    value_in;
    logic                         load;
    logic                         pending;
    logic                         frame_start;
    logic        [NUM_DIGITS-1:0] an;
    logic        [6:0]            segs;

    modport master (
        output value_in,
        output load,
        input  pending,
        input  frame_start,
        input  an,
        input  segs
    );

    modport slave (
        input  value_in,
        input  load,
        output pending,
        output frame_start,
        output an,
        output segs
    );
endinterface

// File: rtl/sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// sseg_scan_driver
//   Scans a signed hex value across NUM_DIGITS multiplexed 7-segment digits.
//   A loaded value is held in a shadow register and only transferred to the
//   displayed (active) register at a frame boundary, so a frame never mixes
//   digits of two different values. Leading zeros are blanked and a negative
//   value gets a minus sign directly left of its most significant digit.
//   Each digit slot starts with GUARD cycles of all anodes off so the
//   segment lines can settle before the next anode turns on.
//
//   Ports:
//     clk   system clock
//     rst   synchronous, active-high reset
//     bus   sseg_scan_driver_if.slave
//             value_in, load        value capture
//             pending, frame_start  status
//             an, segs              registered, active-low display drive
// ---------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 4*(NUM_DIGITS-1),
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 2
) (
    input  logic                clk,
    input  logic                rst,
    sseg_scan_driver_if.slave   bus
);

    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // One spare zero nibble above the value keeps every digit select in range,
    // including the top (sign-only) digit.
    localparam int MAG_W   = 4*NUM_DIGITS;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV-1);
    localparam logic [PRESC_W-1:0] GUARD_C    = PRESC_W'(GUARD);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS-1);
    localparam logic [6:0]         SEG_BLANK  = 7'b111_1111;
    localparam logic [6:0]         SEG_NEG    = 7'b011_1111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0:    code = 7'b100_0000;
            4'h1:    code = 7'b111_1001;
            4'h2:    code = 7'b010_0100;
            4'h3:    code = 7'b011_0000;
            4'h4:    code = 7'b001_1001;
            4'h5:    code = 7'b001_0010;
            4'h6:    code = 7'b000_0010;
            4'h7:    code = 7'b111_1000;
            4'h8:    code = 7'b000_0000;
            4'h9:    code = 7'b001_1000;
            4'hA:    code = 7'b000_1000;
            4'hB:    code = 7'b000_0011;
            4'hC:    code = 7'b100_0110;
            4'hD:    code = 7'b010_0001;
            4'hE:    code = 7'b000_0110;
            default: code = 7'b000_1110;
        endcase
        return code;
    endfunction

    // Magnitude as an unsigned field: the most negative input wraps to
    // 2^(VALUE_W-1), which is exactly its correct unsigned magnitude.
    function automatic logic [VALUE_W-1:0] abs_mag(input logic signed [VALUE_W-1:0] v);
        logic signed [VALUE_W-1:0] negv;
        negv = -v;
        return v[VALUE_W-1] ? $unsigned(negv) : $unsigned(v);
    endfunction

    // Scan control
    logic        [PRESC_W-1:0] prescaler;
    logic        [IDX_W-1:0]   digit_idx;
    logic                      pending;
    logic                      frame_start;
    logic                      boundary;

    // Value registers
    logic signed [VALUE_W-1:0] shadow;
    logic signed [VALUE_W-1:0] active;

    // Digit generation
    logic                      neg_p0;
    logic        [MAG_W-1:0]   mag_p0;
    logic        [IDX_W-1:0]   msd_p0;
    logic        [3:0]         nib_p0;
    logic        [6:0]         seg_code_p0;
    logic                      vld_p0;

    // Registered display drive
    logic        [NUM_DIGITS-1:0] an_p1;
    logic        [6:0]            segs_p1;

    assign boundary = (prescaler == PRESC_LAST) && (digit_idx == IDX_LAST);

    // ---- stage p0: digit code for the current scan position ----
    always_comb begin
        neg_p0      = active[VALUE_W-1];
        mag_p0      = MAG_W'(abs_mag(active));
        msd_p0      = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (mag_p0[4*k +: 4] != 4'h0) begin
                msd_p0 = IDX_W'(k);
            end
        end
        nib_p0      = mag_p0[4*digit_idx +: 4];
        seg_code_p0 = SEG_BLANK;
        if (digit_idx <= msd_p0) begin
            seg_code_p0 = hex_to_seg(nib_p0);
        end else if (neg_p0 && ({1'b0, digit_idx} == ({1'b0, msd_p0} + 1'b1))) begin
            seg_code_p0 = SEG_NEG;
        end
        vld_p0      = (prescaler >= GUARD_C);
    end

    // ---- stage p1: registered anodes/segments, scan and load control ----
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler   <= '0;
            digit_idx   <= '0;
            pending     <= 1'b0;
            frame_start <= 1'b0;
            shadow      <= '0;
            active      <= '0;
            an_p1       <= '1;
            segs_p1     <= SEG_BLANK;
        end else begin
            frame_start <= boundary;

            if (prescaler == PRESC_LAST) begin
                prescaler <= '0;
                digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
            end else begin
                prescaler <= prescaler + 1'b1;
            end

            if (bus.load) begin
                shadow <= bus.value_in;
            end

            // A load coinciding with the boundary bypasses the shadow so it is
            // shown from the very next frame and never appears as pending.
            if (boundary) begin
                active  <= bus.load ? bus.value_in : shadow;
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end

            an_p1   <= vld_p0 ? ~(NUM_DIGITS'(1) << digit_idx) : '1;
            segs_p1 <= vld_p0 ? seg_code_p0 : SEG_BLANK;
        end
    end

    assign bus.pending     = pending;
    assign bus.frame_start = frame_start;
    assign bus.an          = an_p1;
    assign bus.segs        = segs_p1;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_sseg_scan_driver
//   Directed bench for sseg_scan_driver with REFRESH_DIV=4, GUARD=1,
//   NUM_DIGITS=4, VALUE_W=12 (16-cycle frames). The stimulus process pushes
//   the hand-computed {an,segs} pairs for every lit cycle of each frame into
//   a queue; a monitor pops and compares whenever an anode is lit.
// ---------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int ND = 4;
    localparam int VW = 12;
    localparam int RD = 4;
    localparam int GD = 1;

    localparam logic [6:0] BL  = 7'b111_1111;
    localparam logic [6:0] NG  = 7'b011_1111;
    localparam logic [6:0] S0  = 7'b100_0000;
    localparam logic [6:0] S3  = 7'b011_0000;
    localparam logic [6:0] S5  = 7'b001_0010;
    localparam logic [6:0] S8  = 7'b000_0000;
    localparam logic [6:0] SA  = 7'b000_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    sseg_scan_driver_if #(.NUM_DIGITS(ND), .VALUE_W(VW)) bus ();

    sseg_scan_driver #(
        .NUM_DIGITS (ND),
        .VALUE_W    (VW),
        .REFRESH_DIV(RD),
        .GUARD      (GD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [10:0] exp_q[$];
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every lit cycle must be one-hot and match the next queued pair.
    always @(negedge clk) begin
        if (mon_en && (bus.an !== 4'b1111)) begin
            logic [3:0]  an_n;
            logic [10:0] e;
            an_n = ~bus.an;
            check("an_onehot", 32'($countones(an_n)), 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_digit: got an=%b segs=%b, expected no lit anode", bus.an, bus.segs);
            end else begin
                e = exp_q.pop_front();
                check("digit_an_segs", {21'd0, bus.an, bus.segs}, {21'd0, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [6:0] d3, input logic [6:0] d2,
                              input logic [6:0] d1, input logic [6:0] d0);
        logic [3:0] one;
        logic [6:0] code;
        one = 4'b0001;
        for (int i = 0; i < ND; i++) begin
            case (i)
                0:       code = d0;
                1:       code = d1;
                2:       code = d2;
                default: code = d3;
            endcase
            // GUARD=1 of 4 cycles per slot: 3 lit cycles per digit.
            for (int r = 0; r < RD - GD; r++) exp_q.push_back({~(one << i), code});
        end
    endtask

    // One 16-cycle frame starting right after its first edge. ls1/ls2: step at
    // which a load is sampled (0 = none); rs: step at which reset is sampled.
    task automatic run_frame(input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0,
                             input int ls1, input logic [11:0] lv1,
                             input int ls2, input logic [11:0] lv2,
                             input int rs);
        logic exp_pend;
        push_frame(d3, d2, d1, d0);
        exp_pend = 1'b0;
        for (int s = 1; s <= 16; s++) begin
            bus.load     = (s == ls1) || (s == ls2);
            bus.value_in = (s == ls2) ? lv2 : lv1;
            rst          = (s == rs);
            step();
            bus.load = 1'b0;
            if (s == rs) begin
                check("midrst_an", 32'(bus.an), 32'hF);
                check("midrst_segs", 32'(bus.segs), 32'h7F);
                check("midrst_pending", 32'(bus.pending), 32'd0);
                check("midrst_frame_start", 32'(bus.frame_start), 32'd0);
                rst = 1'b0;
                exp_q.delete();
                step();
                check("postrst_an", 32'(bus.an), 32'hF);
                check("postrst_pending", 32'(bus.pending), 32'd0);
                return;
            end
            if ((s == ls1) || (s == ls2)) exp_pend = (s != 15);
            if (s == 15) exp_pend = 1'b0;
            check("pending", 32'(bus.pending), 32'(exp_pend));
            check("frame_start", 32'(bus.frame_start), 32'(s == 15));
            if (s == 1) check("first_anode", 32'(bus.an), 32'hE);
        end
    endtask

    initial begin
        bus.load     = 1'b0;
        bus.value_in = '0;
        rst          = 1'b1;

        for (int r = 0; r < 3; r++) begin
            bus.load     = (r != 1);
            bus.value_in = 12'h5A5 + 12'(r);
            step();
            check("rst_an", 32'(bus.an), 32'hF);
            check("rst_segs", 32'(bus.segs), 32'h7F);
            check("rst_pending", 32'(bus.pending), 32'd0);
            check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        end
        rst      = 1'b0;
        bus.load = 1'b0;
        step();
        check("rel_an", 32'(bus.an), 32'hF);
        check("rel_segs", 32'(bus.segs), 32'h7F);
        check("rel_pending", 32'(bus.pending), 32'd0);
        check("rel_frame_start", 32'(bus.frame_start), 32'd0);
        mon_en = 1'b1;

        // zero shown while 0x0A3 waits for the boundary
        run_frame(BL, BL, BL, S0,  5, 12'h0A3, 0, 12'h000, 0);
        // 0x0A3, load -5 mid-frame
        run_frame(BL, BL, SA, S3,  8, 12'hFFB, 0, 12'h000, 0);
        // -5, load -2048
        run_frame(BL, BL, NG, S5,  3, 12'h800, 0, 12'h000, 0);
        // -2048, two loads: last one (zero) wins
        run_frame(NG, S8, S0, S0,  2, 12'h001, 9, 12'h000, 0);
        // zero, load -128 exactly on the boundary
        run_frame(BL, BL, BL, S0, 15, 12'hF80, 0, 12'h000, 0);
        // -128, load 0x123 then reset mid-slot
        run_frame(BL, NG, S8, S0,  6, 12'h123, 0, 12'h000, 10);
        // scan restarts from index 0 with zero; 0x123 never appears
        run_frame(BL, BL, BL, S0,  0, 12'h000, 0, 12'h000, 0);
        run_frame(BL, BL, BL, S0,  0, 12'h000, 0, 12'h000, 0);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sseg_scan_driver.md
Name: sseg_scan_driver

Overview:
- Upstream driver for the multiplexed 7-segment display.
- Takes a signed hex value on a load strobe and converts it to per-digit active-low segment codes, with leading-zero blanking and a floating negative sign.
- Time-multiplexes the digits through active-low anodes.
- Its segs output is the stream the team's segment decoder and display monitors consume.

Parameters:
- NUM_DIGITS, 4, number of physical digits; digit 0 is rightmost (least significant).
- VALUE_W, 4*(NUM_DIGITS-1), width of the signed two's-complement input value.
- REFRESH_DIV, 50000, clock cycles per digit slot (must be ≥ GUARD+1).
- GUARD, 2, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- value_in  input  VALUE_W  signed value to display
- load  input  1  1-cycle strobe; captures value_in
- pending  output  1  high while a loaded value awaits the frame boundary
- frame_start  output  1  1-cycle pulse when the digit index wraps to 0
- an  output  NUM_DIGITS  anode enables, active low, registered
- segs  output  7  segment code {g,f,e,d,c,b,a}, active low, registered

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it takes effect only on a clk edge.
- Reset values: an=all 1, segs=7'b111_1111 (blank), pending=0, frame_start=0, prescaler=0, index=0, shadow=0, active=0.
- Reset mid-frame: discards any pending value and restarts the scan from index 0.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps. On terminal count, index advances; NUM_DIGITS-1 wraps to 0.
- frame_start: asserted in the cycle after the wrap to 0.
- Load/transfer (no tearing): load writes value_in into the shadow register and sets pending.
  - At a frame boundary (terminal count with index=NUM_DIGITS-1), active<=shadow and pending<=0.
  - Multiple loads within one frame: last one wins.
  - load in the same cycle as a boundary: value_in goes directly to active; pending stays 0.
- Digit generation from active:
  - neg = MSB of active; mag = neg ? -active : active, treated as unsigned VALUE_W bits. The most-negative value gives mag = 2^(VALUE_W-1) and must not overflow.
  - Hex digit k = mag[4k+3:4k] for k < NUM_DIGITS-1.
  - msd = highest k with a nonzero digit, or 0 if mag==0.
  - Digit k shows:
    - the hex code if k ≤ msd;
    - NEG 7'b011_1111 if neg and k==msd+1;
    - blank otherwise.
  - Zero displays "0" with no sign.
- Hex codes, 0..F: 100_0000, 111_1001, 010_0100, 011_0000, 001_1001, 001_0010, 000_0010, 111_1000, 000_0000, 001_1000, 000_1000, 000_0011, 100_0110, 010_0001, 000_0110, 000_1110.
- Output timing: registered, 1 cycle latency. With prescaler=c and index=i in cycle t, at cycle t+1:
  - an = (c ≥ GUARD) ? ~(1<<i) : all 1;
  - segs = code for digit i when an is active, else 7'b111_1111.
  - At most one anode is ever low.
- Value change: takes effect only on the first slot of the frame after transfer.

Test Plan (REFRESH_DIV=4, GUARD=1, NUM_DIGITS=4, VALUE_W=12):
- Reset: assert rst 3 cycles with load toggling -> an=4'b1111, segs=7'b111_1111, pending=0, frame_start=0 throughout and one cycle after release; first anode low is an=4'b1110 at the 2nd cycle after release.
- load 12'h0A3 mid-frame -> pending=1 until the boundary. Next frame: d0 segs=011_0000, d1=000_1000, d2 and d3 blank with an low. Previous value held until the boundary; an never has two zeros.
- load 12'hFFB (-5) -> d0=001_0010, d1=011_1111 (NEG), d2 and d3 blank.
- load 12'h800 (-2048) -> d0=100_0000, d1=100_0000, d2=000_0000, d3=011_1111.
- Ordering: load 12'h001 then 12'h000 in the same frame -> next frame shows d0=100_0000, others blank. load asserted exactly at a boundary cycle -> displayed from that frame's slot 0, pending stays 0.
- Reset mid-slot with pending=1 -> next cycle an=4'b1111, pending=0; the previously loaded value is never displayed; the scan restarts at index 0 with active=0.
